// File: rtl/msi_cpu_cache_controller_if.sv
// CPU, cache-unit and shared-bus signals of the MSI CPU-side cache controller.
// master: the controller; slave: the CPU / cache unit / bus environment around it.
interface msi_cpu_cache_controller_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int TAG_WIDTH     = 8,
    parameter int INDEX_WIDTH   = 6,
    parameter int OFFSET_WIDTH  = 2
);
    logic                     cpu_read;
    logic                     cpu_write;
    logic [ADDRESS_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0]    cpu_data_in;
    logic [DATA_WIDTH-1:0]    cpu_data_out;
    logic                     cpu_done;

    logic [INDEX_WIDTH-1:0]   cache_index;
    logic [OFFSET_WIDTH-1:0]  cache_offset;
    logic [TAG_WIDTH-1:0]     cache_tag_in;
    logic [TAG_WIDTH-1:0]     cache_tag_out;
    logic [1:0]               cache_state_out;
    logic                     cache_hit;
    logic [DATA_WIDTH-1:0]    cache_data_out;
    logic [DATA_WIDTH-1:0]    cache_data_in;
    logic [1:0]               cache_state_in;
    logic                     cache_write_tag;
    logic                     cache_write_state;
    logic                     cache_write_data;

    logic                     bus_request;
    logic                     bus_grant;
    logic [ADDRESS_WIDTH-1:0] bus_address;
    logic                     bus_read;
    logic                     bus_read_exclusive;
    logic                     bus_invalidate;
    logic                     bus_write;
    logic [DATA_WIDTH-1:0]    bus_data_out;
    logic [DATA_WIDTH-1:0]    bus_data_in;
    logic                     bus_ack;

    modport master (
        input  cpu_read, cpu_write, cpu_address, cpu_data_in,
        input  cache_tag_out, cache_state_out, cache_hit, cache_data_out,
        input  bus_grant, bus_data_in, bus_ack,
        output cpu_data_out, cpu_done,
        output cache_index, cache_offset, cache_tag_in, cache_data_in, cache_state_in,
        output cache_write_tag, cache_write_state, cache_write_data,
        output bus_request, bus_address, bus_read, bus_read_exclusive,
        output bus_invalidate, bus_write, bus_data_out
    );

    modport slave (
        output cpu_read, cpu_write, cpu_address, cpu_data_in,
        output cache_tag_out, cache_state_out, cache_hit, cache_data_out,
        output bus_grant, bus_data_in, bus_ack,
        input  cpu_data_out, cpu_done,
        input  cache_index, cache_offset, cache_tag_in, cache_data_in, cache_state_in,
        input  cache_write_tag, cache_write_state, cache_write_data,
        input  bus_request, bus_address, bus_read, bus_read_exclusive,
        input  bus_invalidate, bus_write, bus_data_out
    );
endinterface

// File: rtl/msi_cpu_cache_controller.sv
// CPU-side MSI controller: serves hits combinationally, otherwise arbitrates for the bus to
// upgrade, write back a dirty victim and fill the line word by word; bus beats stall on bus_grant.
module msi_cpu_cache_controller #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int TAG_WIDTH     = 8,
    parameter int INDEX_WIDTH   = 6,
    parameter int OFFSET_WIDTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    msi_cpu_cache_controller_if.master ctl
);
    typedef enum logic [1:0] {S_IDLE, S_UPGRADE, S_WRITEBACK, S_FILL} state_e;

    localparam logic [1:0] ST_INVALID  = 2'd0;
    localparam logic [1:0] ST_SHARED   = 2'd1;
    localparam logic [1:0] ST_MODIFIED = 2'd2;

    state_e                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] count_q, count_d;

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_offset;
    logic                    beat;
    logic                    last_word;

    assign req_tag    = ctl.cpu_address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign req_index  = ctl.cpu_address[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_offset = ctl.cpu_address[OFFSET_WIDTH-1:0];
    assign beat       = ctl.bus_grant & ctl.bus_ack;
    assign last_word  = (count_q == {OFFSET_WIDTH{1'b1}});

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        count_d                = count_q;
        ctl.cpu_done           = 1'b0;
        ctl.cpu_data_out       = '0;
        ctl.cache_index        = req_index;
        ctl.cache_offset       = req_offset;
        ctl.cache_tag_in       = req_tag;
        ctl.cache_data_in      = ctl.cpu_data_in;
        ctl.cache_state_in     = ST_INVALID;
        ctl.cache_write_tag    = 1'b0;
        ctl.cache_write_state  = 1'b0;
        ctl.cache_write_data   = 1'b0;
        ctl.bus_request        = (state_q != S_IDLE);
        ctl.bus_address        = {req_tag, req_index, count_q};
        ctl.bus_read           = 1'b0;
        ctl.bus_read_exclusive = 1'b0;
        ctl.bus_invalidate     = 1'b0;
        ctl.bus_write          = 1'b0;
        ctl.bus_data_out       = ctl.cache_data_out;

        case (state_q)
            S_IDLE: begin
                if (ctl.cpu_read || ctl.cpu_write) begin
                    if (!ctl.cache_hit) begin
                        state_d = (ctl.cache_state_out == ST_MODIFIED) ? S_WRITEBACK : S_FILL;
                    end else if (!ctl.cpu_write) begin
                        ctl.cpu_done     = 1'b1;
                        ctl.cpu_data_out = ctl.cache_data_out;
                    end else if (ctl.cache_state_out == ST_MODIFIED) begin
                        ctl.cache_write_data = 1'b1;
                        ctl.cpu_done         = 1'b1;
                    end else begin
                        state_d = S_UPGRADE;
                    end
                end
            end
            S_UPGRADE: begin
                ctl.bus_address = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
                // A snoop may invalidate the line while we wait; then a full exclusive fill is needed.
                if (!ctl.cache_hit) begin
                    state_d = S_FILL;
                end else if (ctl.bus_grant) begin
                    ctl.bus_invalidate = 1'b1;
                    if (ctl.bus_ack) begin
                        ctl.cache_write_state = 1'b1;
                        ctl.cache_state_in    = ST_MODIFIED;
                        ctl.cache_write_data  = 1'b1;
                        ctl.cpu_done          = 1'b1;
                        state_d               = S_IDLE;
                    end
                end
            end
            S_WRITEBACK: begin
                ctl.cache_offset = count_q;
                ctl.bus_address  = {ctl.cache_tag_out, req_index, count_q};
                ctl.bus_write    = ctl.bus_grant;
                if (beat) begin
                    count_d = count_q + 1'b1;
                    if (last_word) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                ctl.cache_offset       = count_q;
                ctl.cache_data_in      = ctl.bus_data_in;
                ctl.bus_read           = ctl.bus_grant & ~ctl.cpu_write;
                ctl.bus_read_exclusive = ctl.bus_grant & ctl.cpu_write;
                if (beat) begin
                    ctl.cache_write_data = 1'b1;
                    count_d              = count_q + 1'b1;
                    // Invalidate on the first word so a reset-aborted fill never leaves a valid, mixed line.
                    if (last_word) begin
                        ctl.cache_write_tag   = 1'b1;
                        ctl.cache_write_state = 1'b1;
                        ctl.cache_state_in    = ctl.cpu_write ? ST_MODIFIED : ST_SHARED;
                        state_d               = S_IDLE;
                    end else if (count_q == '0) begin
                        ctl.cache_write_state = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
